// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the request legality check used at acceptance.
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_FIN
  } lsu_state_e;

  // A request is rejected when its width code is undefined for the access
  // direction, or when the address is not aligned to the access size.
  function automatic logic req_bad(input logic we, input logic [2:0] funct3,
                                   input logic [1:0] offset);
    logic illegal;
    logic misaligned;
    if (we) illegal = !(funct3 inside {LSU_B, LSU_H, LSU_W});
    else    illegal = !(funct3 inside {LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU});
    case (funct3)
      LSU_H, LSU_HU: misaligned = offset[0];
      LSU_W:         misaligned = (offset != 2'b00);
      default:       misaligned = 1'b0;
    endcase
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: load extract/extend and sub-word store merge.
// Lanes are little-endian, lane k occupies bits [8k+7:8k].
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output gets a default first, otherwise a latch is inferred.
    byte_sel   = word[{offset, 3'b000} +: 8];
    half_sel   = offset[1] ? word[31:16] : word[15:0];
    load_data  = word;
    store_data = wdata;

    case (funct3)
      LSU_B:   load_data = {{24{byte_sel[7]}}, byte_sel};
      LSU_BU:  load_data = {24'b0, byte_sel};
      LSU_H:   load_data = {{16{half_sel[15]}}, half_sel};
      LSU_HU:  load_data = {16'b0, half_sel};
      default: load_data = word;
    endcase

    case (funct3)
      LSU_B: begin
        store_data = word;
        store_data[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      LSU_H: begin
        store_data = word;
        store_data[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store front end for a word-addressed memory without byte
// enables; sub-word stores go through read-modify-write. All outputs registered.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ,
  input  logic              WE,
  input  logic [2:0]        FUNCT3,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [DATA_W-1:0] RDATA,
  output logic              MEM_EN,
  output logic              MEM_RW,
  output logic [31:0]       MEM_ADDR,
  output logic [DATA_W-1:0] MEM_DIN,
  input  logic [DATA_W-1:0] MEM_DOUT
);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;

  logic        busy_d, done_d, err_d, mem_en_d, mem_rw_d;
  logic [31:0] rdata_d, mem_addr_d, mem_din_d;
  logic [31:0] load_data, store_data;

  lsu_align u_align (
    .word       (MEM_DOUT),
    .wdata      (wdata_q),
    .offset     (off_q),
    .funct3     (f3_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    f3_d       = f3_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    err_d      = 1'b0;
    rdata_d    = RDATA;
    mem_addr_d = MEM_ADDR;
    mem_din_d  = MEM_DIN;

    case (state_q)
      S_IDLE: begin
        if (REQ) begin
          we_d       = WE;
          f3_d       = FUNCT3;
          off_d      = ADDR[1:0];
          wdata_d    = WDATA;
          mem_addr_d = 32'(ADDR[ADDR_W-1:2]);
          if (req_bad(WE, FUNCT3, ADDR[1:0])) begin
            state_d = S_FIN;
            err_d   = 1'b1;
          end else if (WE && FUNCT3 == LSU_W) begin
            state_d   = S_WR;
            mem_din_d = WDATA;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD:  state_d = S_CAP;
      S_CAP: begin
        // Read data is on MEM_DOUT now: finish the load or build the merged word.
        if (we_q) begin
          mem_din_d = store_data;
          state_d   = S_WR;
        end else begin
          rdata_d = load_data;
          state_d = S_FIN;
        end
      end
      S_WR:    state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Moore outputs are precomputed from the next state so they register cleanly.
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_FIN);
    mem_en_d = (state_d == S_RD) || (state_d == S_WR);
    mem_rw_d = (state_d == S_WR);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      f3_q     <= 3'b000;
      off_q    <= 2'b00;
      wdata_q  <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      RDATA    <= '0;
      MEM_EN   <= 1'b0;
      MEM_RW   <= 1'b0;
      MEM_ADDR <= '0;
      MEM_DIN  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q  <= state_d;
      we_q     <= we_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      BUSY     <= busy_d;
      DONE     <= done_d;
      ERR      <= err_d;
      RDATA    <= rdata_d;
      MEM_EN   <= mem_en_d;
      MEM_RW   <= mem_rw_d;
      MEM_ADDR <= mem_addr_d;
      MEM_DIN  <= mem_din_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: word-addressed memory model,
// transaction-level reference model with shadow memory, directed + random traffic.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        REQ = 1'b0;
  logic        WE = 1'b0;
  logic [2:0]  FUNCT3 = 3'b000;
  logic [31:0] ADDR = '0;
  logic [31:0] WDATA = '0;
  logic        BUSY, DONE, ERR, MEM_EN, MEM_RW;
  logic [31:0] RDATA, MEM_ADDR, MEM_DIN;
  logic [31:0] mem_dout = '0;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .REQ      (REQ),
    .WE       (WE),
    .FUNCT3   (FUNCT3),
    .ADDR     (ADDR),
    .WDATA    (WDATA),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERR      (ERR),
    .RDATA    (RDATA),
    .MEM_EN   (MEM_EN),
    .MEM_RW   (MEM_RW),
    .MEM_ADDR (MEM_ADDR),
    .MEM_DIN  (MEM_DIN),
    .MEM_DOUT (mem_dout)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word-addressed data memory: synchronous read, write on enabled RW edge.
  logic [31:0] mem    [bit [31:0]];
  logic [31:0] shadow [bit [31:0]];
  int wr_count = 0;

  function automatic logic [31:0] mem_rd(input bit [31:0] a);
    if (mem.exists(a)) return mem[a];
    return '0;
  endfunction

  function automatic logic [31:0] shadow_rd(input bit [31:0] a);
    if (shadow.exists(a)) return shadow[a];
    return '0;
  endfunction

  always @(posedge CLK) begin
    if (MEM_EN) begin
      if (MEM_RW) begin
        mem[MEM_ADDR] = MEM_DIN;
        wr_count++;
      end else begin
        mem_dout <= mem_rd(MEM_ADDR);
      end
    end
  end

  // Transaction-level reference: legality, latency table, lane arithmetic.
  bit          m_busy = 1'b0;
  bit          m_bad, m_we;
  int          m_cnt = 0;
  int          m_lat = 0;
  int          m_wbase = 0;
  int          acc_count = 0;
  logic [31:0] m_waddr = '0;
  logic [31:0] m_rdata = '0;
  logic [31:0] m_newword = '0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_busy  = 1'b0;
      m_cnt   = 0;
      m_rdata = '0;
    end else if (m_busy) begin
      if (m_cnt == m_lat) m_busy = 1'b0;
      else m_cnt++;
    end else if (REQ) begin
      int sz, shift;
      bit legal, misal;
      logic [31:0] mask, old, v;
      sz    = int'(FUNCT3[1:0]);
      legal = WE ? (FUNCT3 <= 3'd2) : !(FUNCT3 inside {3'd3, 3'd6, 3'd7});
      misal = (sz < 3) && ((ADDR % (32'd1 << sz)) != 0);
      m_bad   = !legal || misal;
      m_we    = WE;
      m_waddr = ADDR >> 2;
      shift   = 8 * int'(ADDR % 4);
      mask    = (sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
      m_lat   = m_bad ? 1 : WE ? ((sz == 2) ? 2 : 4) : 3;
      old     = shadow_rd(m_waddr);
      if (!m_bad && !WE) begin
        v = (old >> shift) & mask;
        if (!FUNCT3[2] && sz < 2 && v[(8 << sz) - 1]) v = v | ~mask;
        m_rdata = v;
      end
      if (!m_bad && WE) begin
        m_newword = (old & ~(mask << shift)) | ((WDATA & mask) << shift);
        shadow[m_waddr] = m_newword;
      end
      m_wbase = wr_count;
      m_cnt   = 1;
      m_busy  = 1'b1;
      acc_count++;
    end
  end

  bit exp_done, exp_en, exp_rw;

  always @(negedge CLK) begin
    if (RST_N) begin
      exp_done = m_busy && (m_cnt == m_lat);
      exp_en   = m_busy && !m_bad && (m_cnt == 1 || (m_we && m_lat == 4 && m_cnt == 3));
      exp_rw   = m_busy && !m_bad && m_we && (m_cnt == m_lat - 1);
      check("busy", BUSY, m_busy);
      check("done", DONE, exp_done);
      check("mem_en", MEM_EN, exp_en);
      check("mem_rw", MEM_RW, exp_rw);
      if (exp_en) check("mem_addr", MEM_ADDR, m_waddr);
      if (exp_rw) check("mem_din", MEM_DIN, m_newword);
      if (exp_done) begin
        check("err", ERR, m_bad);
        if (!m_we && !m_bad) check("rdata", RDATA, m_rdata);
        check("write_count", wr_count - m_wbase, (m_we && !m_bad) ? 1 : 0);
        check("mem_word", mem_rd(m_waddr), shadow_rd(m_waddr));
      end else begin
        check("err_idle", ERR, 0);
      end
    end
  end

  // Presents one request (REQ left high) and returns at the DONE negedge.
  task automatic issue(input bit we, input bit [2:0] f3, input bit [31:0] a,
                       input bit [31:0] wd, output int lat, output int en_cycles,
                       output logic [31:0] seen_addr, output int rw_cycles);
    int start = acc_count;
    int n = 0;
    lat = 0; en_cycles = 0; rw_cycles = 0; seen_addr = '0;
    REQ = 1'b1; WE = we; FUNCT3 = f3; ADDR = a; WDATA = wd;
    while (acc_count == start && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (acc_count == start) begin
      check("accept_timeout", BUSY, 1);
      return;
    end
    lat = 1;
    forever begin
      if (MEM_EN) begin en_cycles++; seen_addr = MEM_ADDR; end
      if (MEM_RW) rw_cycles++;
      if (DONE || lat >= 10) break;
      @(negedge CLK);
      lat++;
    end
    if (!DONE) check("done_timeout", DONE, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_done"}, DONE, 0);
    check({tag, "_err"}, ERR, 0);
    check({tag, "_rdata"}, RDATA, 0);
    check({tag, "_mem_en"}, MEM_EN, 0);
    check({tag, "_mem_rw"}, MEM_RW, 0);
    check({tag, "_mem_addr"}, MEM_ADDR, 0);
    check({tag, "_mem_din"}, MEM_DIN, 0);
  endtask

  // Starts SB 0x77 @0x20 and returns at the negedge of its write cycle.
  task automatic run_to_write();
    int n = 0;
    REQ = 1'b1; WE = 1'b1; FUNCT3 = 3'b000; ADDR = 32'h20; WDATA = 32'h0000_0077;
    do begin
      @(negedge CLK);
      n++;
    end while (!(MEM_EN && MEM_RW) && n < 12);
    REQ = 1'b0;
    check("reach_wr", MEM_RW, 1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, en, rw;
    logic [31:0] sa;

    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RST_N = 1'b1;
    @(negedge CLK);

    // SW then LW round trip
    issue(1, 3'b010, 32'h10, 32'hDEAD_BEEF, lat, en, sa, rw);
    check("sw_lat", lat, 2); check("sw_rw_cycles", rw, 1); check("sw_addr", sa, 4);
    issue(0, 3'b010, 32'h10, 32'h0, lat, en, sa, rw);
    check("lw_lat", lat, 3); check("lw_rdata", RDATA, 32'hDEAD_BEEF); check("lw_rw", rw, 0);

    // SB merge, signed/unsigned byte loads
    issue(1, 3'b010, 32'h10, 32'h1122_3344, lat, en, sa, rw);
    issue(1, 3'b000, 32'h11, 32'h1234_56A5, lat, en, sa, rw);
    check("sb_lat", lat, 4); check("sb_rw_cycles", rw, 1); check("sb_word", mem_rd(4), 32'h1122_A544);
    issue(0, 3'b000, 32'h11, 32'h0, lat, en, sa, rw);
    check("lb_rdata", RDATA, 32'hFFFF_FFA5);
    issue(0, 3'b100, 32'h11, 32'h0, lat, en, sa, rw);
    check("lbu_rdata", RDATA, 32'h0000_00A5);

    // SH upper half, signed/unsigned half loads
    issue(1, 3'b001, 32'h12, 32'hFFFF_8001, lat, en, sa, rw);
    check("sh_lat", lat, 4); check("sh_word", mem_rd(4), 32'h8001_A544);
    issue(0, 3'b001, 32'h12, 32'h0, lat, en, sa, rw);
    check("lh_rdata", RDATA, 32'hFFFF_8001);
    issue(0, 3'b101, 32'h12, 32'h0, lat, en, sa, rw);
    check("lhu_rdata", RDATA, 32'h0000_8001);

    // Misaligned and illegal requests
    issue(0, 3'b010, 32'h13, 32'h0, lat, en, sa, rw);
    check("lw_mis_lat", lat, 1); check("lw_mis_err", ERR, 1); check("lw_mis_en", en, 0);
    issue(1, 3'b001, 32'h15, 32'hFFFF_FFFF, lat, en, sa, rw);
    check("sh_mis_lat", lat, 1); check("sh_mis_err", ERR, 1); check("sh_mis_en", en, 0);
    check("mis_word4", mem_rd(4), 32'h8001_A544); check("mis_word5", mem_rd(5), 32'h0);
    issue(0, 3'b011, 32'h20, 32'h0, lat, en, sa, rw);
    check("ld_ill_err", ERR, 1); check("ld_ill_en", en, 0);
    issue(1, 3'b100, 32'h20, 32'h0, lat, en, sa, rw);
    check("st_ill_err", ERR, 1); check("st_ill_en", en, 0);

    // Address wrap at the top of the space
    issue(1, 3'b010, 32'hFFFF_FFFC, 32'h5A5A_0FF0, lat, en, sa, rw);
    check("wrap_addr", sa, 32'h3FFF_FFFF);
    issue(0, 3'b010, 32'hFFFF_FFFC, 32'h0, lat, en, sa, rw);
    check("wrap_rdata", RDATA, 32'h5A5A_0FF0);

    // Back-to-back loads with REQ held high
    issue(0, 3'b010, 32'h10, 32'h0, lat, en, sa, rw);
    check("b2b0", RDATA, 32'h8001_A544);
    issue(0, 3'b000, 32'h12, 32'h0, lat, en, sa, rw);
    check("b2b1", RDATA, 32'h0000_0001);
    issue(0, 3'b101, 32'h10, 32'h0, lat, en, sa, rw);
    check("b2b2", RDATA, 32'h0000_A544);
    issue(0, 3'b010, 32'hFFFF_FFFC, 32'h0, lat, en, sa, rw);
    check("b2b3", RDATA, 32'h5A5A_0FF0);

    // Reset during the write cycle: before and after the write edge
    issue(1, 3'b010, 32'h20, 32'hCAFE_F00D, lat, en, sa, rw);
    run_to_write();
    #1 RST_N = 1'b0;
    #1 check_reset_outputs("rst_wr");
    @(posedge CLK);
    @(negedge CLK);
    check("rst_before_edge_word", mem_rd(8), 32'hCAFE_F00D);
    shadow[32'h8] = 32'hCAFE_F00D;
    RST_N = 1'b1;
    @(negedge CLK);
    run_to_write();
    @(posedge CLK);
    #1 RST_N = 1'b0;
    #1 check_reset_outputs("rst_fin");
    @(negedge CLK);
    check("rst_after_edge_word", mem_rd(8), 32'hCAFE_F077);
    RST_N = 1'b1;
    @(negedge CLK);

    // Randomized traffic with REQ held high
    for (int i = 0; i < 300; i++) begin
      bit [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFFC | $urandom_range(0, 3))
                                      : 32'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
            lat, en, sa, rw);
    end
    REQ = 1'b0;
    repeat (3) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
